// File: rtl/ones_count_accum.sv
// Frame accumulator for 2-bit ones-count samples: sums FRAME_LEN valid samples,
// saturates at 2^SUM_W-1, and reports the total with a one-cycle done pulse.
module ones_count_accum #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             y1,
    input  logic             y0,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic             sat
);

    localparam int EXT_W = SUM_W + 1;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [SUM_W-1:0] SUM_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_nxt;
    logic             busy_nxt, done_nxt;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat_flag;
    logic             capture, last, frame_go;
    logic [SUM_W:0]   add_res;

    // Returns {overflow, clamped_sum}; the add is carried out one bit wider
    // so the overflow is visible before clamping.
    function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [1:0]       s);
        logic [EXT_W-1:0] wide;
        wide = {1'b0, a} + EXT_W'(s);
        if (wide > {1'b0, SUM_MAX})
            return {1'b1, SUM_MAX};
        return wide;
    endfunction

    assign capture  = (state == ACCUM) && in_valid;
    assign last     = capture && (cnt == CNT_LAST);
    assign frame_go = start && ((state == IDLE) || (state == DONE));
    assign add_res  = sat_add(acc, {y1, y0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Flags are decoded from the next state so busy/done come straight from flops.
    always_comb begin
        busy_nxt = (state_nxt == ACCUM);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // Samples are only looked at under capture, so X on y1/y0 while idle or
    // in a gap never reaches the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
            sum      <= '0;
            sat      <= 1'b0;
        end else if (frame_go) begin
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else if (capture) begin
            acc      <= add_res[SUM_W-1:0];
            sat_flag <= sat_flag | add_res[SUM_W];
            cnt      <= cnt + CNT_W'(1);
            if (last) begin
                sum <= add_res[SUM_W-1:0];
                sat <= sat_flag | add_res[SUM_W];
            end
        end
    end

endmodule

// File: tb/tb_ones_count_accum.sv
// Directed bench for ones_count_accum: two instances (default widths and SUM_W=4)
// share stimulus and are checked every cycle against a frame-level model.
module tb_ones_count_accum;

    logic clk, rst_n, start, in_valid, y1, y0;
    logic busy0, done0, sat0;
    logic [4:0] sum0;
    logic busy1, done1, sat1;
    logic [3:0] sum1;

    int checks = 0;
    int passed = 0;

    ones_count_accum #(.FRAME_LEN(8), .SUM_W(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .y1(y1), .y0(y0), .busy(busy0), .done(done0), .sum(sum0), .sat(sat0));

    ones_count_accum #(.FRAME_LEN(8), .SUM_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .y1(y1), .y0(y0), .busy(busy1), .done(done1), .sum(sum1), .sat(sat1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // Frame-level model: a frame is "open" between an accepted start and the
    // FRAME_LEN-th valid sample; the reported sum is the unclamped total
    // limited to the instance maximum, and sat says whether the total exceeded it.
    localparam int FL = 8;
    int  max_v [2] = '{31, 15};
    bit  m_open [2];
    int  m_cnt  [2];
    int  m_tot  [2];
    bit  e_busy [2];
    bit  e_done [2];
    bit  e_sat  [2];
    int  e_sum  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_open[i] = 0; m_cnt[i] = 0; m_tot[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_sat[i] = 0; e_sum[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_open[i] = 0; m_cnt[i] = 0; m_tot[i] = 0;
                    e_busy[i] = 0; e_done[i] = 0; e_sat[i] = 0; e_sum[i] = 0;
                end else begin
                    bit finished;
                    finished = 0;
                    if (m_open[i]) begin
                        if (in_valid) begin
                            m_tot[i] += 2 * int'(y1) + int'(y0);
                            m_cnt[i]++;
                            if (m_cnt[i] == FL) begin
                                e_sum[i] = (m_tot[i] > max_v[i]) ? max_v[i] : m_tot[i];
                                e_sat[i] = (m_tot[i] > max_v[i]);
                                m_open[i] = 0;
                                finished = 1;
                            end
                        end
                    end else if (start) begin
                        m_open[i] = 1; m_cnt[i] = 0; m_tot[i] = 0;
                    end
                    e_done[i] = finished;
                    e_busy[i] = m_open[i];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("busy0", int'(busy0), int'(e_busy[0]));
            check("done0", int'(done0), int'(e_done[0]));
            check("sum0",  int'(sum0),  e_sum[0]);
            check("sat0",  int'(sat0),  int'(e_sat[0]));
            check("busy1", int'(busy1), int'(e_busy[1]));
            check("done1", int'(done1), int'(e_done[1]));
            check("sum1",  int'(sum1),  e_sum[1]);
            check("sat1",  int'(sat1),  int'(e_sat[1]));
        end
    end

    task automatic cyc(input bit s, input bit v, input bit a, input bit b);
        start = s; in_valid = v; y1 = a; y0 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy0 | busy1), 0);
        check({tag, "_done"}, int'(done0 | done1), 0);
        check({tag, "_sum0"}, int'(sum0), 0);
        check({tag, "_sum1"}, int'(sum1), 0);
        check({tag, "_sat"},  int'(sat0 | sat1), 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 0; in_valid = 0; y1 = 0; y0 = 0;
        // Asynchronous reset between edges, checked before the first edge.
        #3 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // Full frame of 3s; the start-cycle sample must be ignored.
        cyc(1, 1, 1, 1);
        for (int k = 0; k < 8; k++) cyc(0, 1, 1, 1);
        check("A_done0", int'(done0), 1);
        check("A_busy0", int'(busy0), 0);
        check("A_sum0",  int'(sum0), 24);
        check("A_sat0",  int'(sat0), 0);
        check("A_sum1",  int'(sum1), 15);
        check("A_sat1",  int'(sat1), 1);
        check("A_model", e_sum[0], 24);
        cyc(0, 0, 0, 0);
        check("A_done_gone", int'(done0), 0);

        // Valid data in IDLE is ignored.
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, 1);
        check("idle_sum0", int'(sum0), 24);
        check("idle_done", int'(done0), 0);
        check("idle_busy", int'(busy0), 0);

        // Reset in the middle of a frame.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 1, 1);
        rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        #1 rst_n = 1'b1;
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 1, 0);
        check("R_sum0", int'(sum0), 16);
        check("R_sum1", int'(sum1), 15);
        check("R_sat1", int'(sat1), 1);
        check("R_model", e_sum[1], 15);
        cyc(0, 0, 0, 0);

        // Gapped frame of 1s; gaps carry 3s and start pulses.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 0, 1);
            if (k < 7) begin
                cyc(1, 0, 1, 1);
                if (k == 3) check("B_busy_gap", int'(busy0), 1);
            end
        end
        check("B_done0", int'(done0), 1);
        check("B_sum0",  int'(sum0), 8);
        check("B_sum1",  int'(sum1), 8);
        check("B_sat1",  int'(sat1), 0);

        // Back-to-back: start in the DONE cycle, frame of zeros.
        cyc(1, 0, 0, 0);
        check("C_busy_b2b", int'(busy0), 1);
        check("C_done_b2b", int'(done0), 0);
        check("C_sum_hold", int'(sum0), 8);
        for (int k = 0; k < 8; k++) cyc(0, 1, 0, 0);
        check("C_sum0", int'(sum0), 0);
        check("C_sat1", int'(sat1), 0);
        check("C_done", int'(done1), 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
